// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: a sequential FIR filter with one shared N x N multiplier.
// Each accepted sample sets off one pass. The pass spends TAPS cycles in MAC,
// one per tap, then one cycle in DONE. The sequencer then returns to IDLE, so
// it takes one sample every TAPS+2 cycles.
// Optional feature macro FIR_COEF_LOAD_EN: when it is defined, the coefficients
// are held in registers and can be written while idle. When it is undefined,
// every coefficient is the constant 10 and the coefficient write port does
// nothing.
module fir_mac_sequencer #(
  parameter int N     = 4,
  parameter int TAPS  = 10,
  parameter int ACC_W = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             coef_we,
  input  logic [3:0]       coef_addr,
  input  logic [N-1:0]     coef_data,
  output logic [ACC_W-1:0] out,
  output logic             out_valid,
  output logic             busy
);

  localparam int IW = $clog2(TAPS);
  localparam logic [N-1:0] H_RESET = N'(10);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [N-1:0]     x [TAPS];
  logic [IW-1:0]    idx;
  logic [ACC_W-1:0] acc;
  logic [N-1:0]     h_sel;
  logic [2*N-1:0]   prod;
  logic             accept;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;

`ifdef FIR_COEF_LOAD_EN
  logic [N-1:0] h [TAPS];
  logic         coef_wr;

  // A write is only taken while idle, and only for an address inside the tap range.
  assign coef_wr = coef_we && (state == IDLE) && ({1'b0, coef_addr} < 5'(TAPS));

  // Coefficient registers. Reset loads every tap with 10.
  // NOTE: this array is reset on purpose, because the filter needs a defined
  // set of taps after reset. Plain storage arrays are normally left unreset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < TAPS; k++) h[k] <= H_RESET;
    end else if (coef_wr) begin
      h[coef_addr[IW-1:0]] <= coef_data;
    end
  end

  assign h_sel = h[idx];
`else
  // Every tap is fixed at 10. The write port is folded into this signal so
  // that it is visibly consumed.
  logic unused_coef;
  assign unused_coef = ^{coef_we, coef_addr, coef_data};
  assign h_sel       = H_RESET;
`endif

  // Shared multiplier. It is fed the tap that the sequencer is visiting.
  assign prod = x[idx] * h_sel;

  // State register.
  // NOTE: sequential state is written with non-blocking assignments. Every flop
  // then samples its inputs from before the edge, whatever order the code is in.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. A pending sample outside IDLE has no effect here.
  // NOTE: the default is assigned first, so every path drives state_nxt and no
  // latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = MAC;
      MAC:     if (idx == IW'(TAPS - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: the delay line, the tap index, the accumulator and the result register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < TAPS; k++) x[k] <= '0;
      acc       <= '0;
      idx       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            for (int k = TAPS - 1; k > 0; k--) x[k] <= x[k-1];
            x[0] <= in;
            acc  <= '0;
            idx  <= '0;
          end
        end
        MAC: begin
          // The full-width product is zero-extended. The sum wraps at the accumulator width.
          acc <= acc + ACC_W'(prod);
          idx <= idx + IW'(1);
        end
        DONE: begin
          out       <= acc;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Testbench for fir_mac_sequencer. A reference model in the bench tracks the
// sample history and the tap set and works out each output as a plain
// convolution sum. It also checks when each pulse appears and how the
// handshake behaves.
// The bench follows the FIR_COEF_LOAD_EN macro in the same way as the design.
module tb_fir_mac_sequencer;

  localparam int N     = 4;
  localparam int TAPS  = 10;
  localparam int ACC_W = 18;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     in;
  logic             in_valid;
  logic             in_ready;
  logic             coef_we;
  logic [3:0]       coef_addr;
  logic [N-1:0]     coef_data;
  logic [ACC_W-1:0] out;
  logic             out_valid;
  logic             busy;

  fir_mac_sequencer #(.N(N), .TAPS(TAPS), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  typedef struct {
    int               cyc;
    logic [ACC_W-1:0] val;
  } exp_t;

  int unsigned      hist [TAPS];
  int unsigned      mh   [TAPS];
  exp_t             expq [$];
  logic [ACC_W-1:0] got  [$];
  logic [ACC_W-1:0] model_out = '0;
  int               cyc = 0;
  int               busy_until = 0;
  logic             m_ready;
  logic             exp_pulse;

  // The filter output is the sum of each past sample times its tap, reduced modulo 2^ACC_W.
  function automatic logic [ACC_W-1:0] model_fir();
    longint unsigned s;
    s = 0;
    for (int k = 0; k < TAPS; k++) s += longint'(hist[k]) * longint'(mh[k]);
    return s[ACC_W-1:0];
  endfunction

  initial begin
    for (int k = 0; k < TAPS; k++) begin
      hist[k] = 0;
      mh[k]   = 10;
    end
  end

  // Monitor at the falling edge. It first compares the outputs with the model,
  // then applies whatever the next rising edge will do.
  always @(negedge clk) begin
    m_ready   = (cyc >= busy_until);
    exp_pulse = (expq.size() > 0) && (expq[0].cyc == cyc);
    check("in_ready", in_ready, m_ready);
    check("busy", busy, !m_ready);
    check("out_valid", out_valid, exp_pulse);
    if (exp_pulse) begin
      model_out = expq[0].val;
      void'(expq.pop_front());
    end
    check("out", out, model_out);
    if (out_valid) got.push_back(out);

    if (!reset) begin
      for (int k = 0; k < TAPS; k++) begin
        hist[k] = 0;
        mh[k]   = 10;
      end
      expq.delete();
      model_out  = '0;
      busy_until = cyc + 1;
    end else if (m_ready) begin
`ifdef FIR_COEF_LOAD_EN
      if (coef_we && coef_addr < TAPS) mh[coef_addr] = coef_data;
`endif
      if (in_valid) begin
        for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = in;
        expq.push_back('{cyc + TAPS + 2, model_fir()});
        busy_until = cyc + TAPS + 2;
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample and wait, within a cycle limit, for it to be accepted.
  // With keep set, in_valid stays high afterwards.
  task automatic send(input logic [N-1:0] v, input bit keep);
    int t;
    in       = v;
    in_valid = 1'b1;
    t        = 0;
    while (!in_ready && t < 200) begin
      step();
      t++;
    end
    check("send_timeout", in_ready, 1'b1);
    step();
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (TAPS + 4) step();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
  endtask

  task automatic impulse_check(input string tag);
    got.delete();
    send(N'(1), 1'b0);
    repeat (TAPS) send('0, 1'b0);
    drain();
    check({tag, "_count"}, got.size(), TAPS + 1);
    for (int k = 0; k < got.size(); k++)
      check(tag, got[k], (k < TAPS) ? 10 : 0);
  endtask

  initial begin
    reset     = 1'b0;
    in        = '0;
    in_valid  = 1'b0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    repeat (3) step();
    reset = 1'b1;
    step();

    // Impulse response.
    impulse_check("impulse");

    // Step response: the output ramps up by 150 per sample and holds at 1500.
    got.delete();
    repeat (12) send(N'(15), 1'b0);
    drain();
    check("step_count", got.size(), 12);
    for (int k = 0; k < got.size(); k++)
      check("step", got[k], (k < 9) ? 150 * (k + 1) : 1500);

    // Back-pressure: in_valid is held high and a new sample goes in after each accept.
    got.delete();
    for (int i = 0; i < 24; i++) send(N'($urandom), 1'b1);
    in_valid = 1'b0;
    drain();
    check("bp_count", got.size(), 24);

    // Random traffic. Samples arrive at random gaps, and coefficient writes
    // are random in time and address.
    for (int i = 0; i < 60; i++) begin
      coef_we   = ($urandom_range(0, 2) == 0);
      coef_addr = 4'($urandom_range(0, 15));
      coef_data = N'($urandom);
      send(N'($urandom), 1'b0);
      coef_we = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        coef_we   = ($urandom_range(0, 3) == 0);
        coef_addr = 4'($urandom_range(0, 15));
        coef_data = N'($urandom);
        step();
      end
      coef_we = 1'b0;
    end
    drain();

`ifdef FIR_COEF_LOAD_EN
    // Coefficient load followed by an impulse.
    do_reset();
    step();
    coef_we = 1'b1; coef_addr = 4'd3; coef_data = '0;      step();
    coef_addr = 4'd0; coef_data = N'(5);                   step();
    coef_we = 1'b0;
    got.delete();
    send(N'(1), 1'b0);
    repeat (TAPS - 1) send('0, 1'b0);
    drain();
    check("coef_count", got.size(), TAPS);
    for (int k = 0; k < got.size(); k++)
      check("coef_impulse", got[k], (k == 0) ? 5 : (k == 3) ? 0 : 10);
    do_reset();
    step();
`endif

    // Reset in the middle of a pass, at idx = 4.
    got.delete();
    send(N'(7), 1'b0);
    repeat (4) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("rst_out", out, 0);
    check("rst_ready", in_ready, 1'b1);
    drain();
    check("rst_no_pulse", got.size(), 0);
    impulse_check("post_rst_impulse");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fir_mac_sequencer.md
FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 Parameter N, default 4: input sample and coefficient width, in bits.
REQ-002 Parameter TAPS, default 10: number of filter taps (legal range 2..16).
REQ-003 Parameter ACC_W, default 18: accumulator and output width, in bits.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: synchronous reset, active-low (0 = reset).
REQ-006 Port in, input, N: unsigned input sample.
REQ-007 Port in_valid, input, 1: a sample is present on in.
REQ-008 Port in_ready, output, 1: the block can accept a sample this cycle.
REQ-009 Port coef_we, input, 1: coefficient write strobe.
REQ-010 Port coef_addr, input, 4: index of the coefficient to write (0..TAPS-1).
REQ-011 Port coef_data, input, N: unsigned coefficient value to write.
REQ-012 Port out, output, ACC_W: filter result.
REQ-013 Port out_valid, output, 1: one-cycle pulse marking a new value on out.
REQ-014 Port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-015 The block SHALL time-share one N x N unsigned multiplier across all TAPS taps.
REQ-016 The FSM SHALL have three states: IDLE, MAC and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; a sample is accepted when in_valid=1 and in_ready=1.
REQ-018 On accept: delay line shifts (x[k] <= x[k-1], x[0] <= in), acc <= 0, idx <= 0, state -> MAC.
REQ-019 In MAC, each cycle: acc <= acc + x[idx]*h[idx], then idx increments; after idx = TAPS-1 the state moves to DONE.
REQ-020 In DONE: out <= final acc, out_valid = 1 for exactly one cycle, state -> IDLE.
REQ-021 Latency: a sample accepted at edge T gives out_valid high in the cycle after edge T+TAPS+1; throughput is one sample per TAPS+2 cycles.
REQ-022 out SHALL hold its value between DONE pulses.
REQ-023 Each product SHALL be 2N bits and be zero-extended to ACC_W before accumulation; the accumulator wraps modulo 2^ACC_W (no saturation).
REQ-024 A coefficient write takes effect only in IDLE with coef_addr < TAPS; writes outside IDLE or with coef_addr >= TAPS are ignored.
REQ-025 If coef_we and an accepted sample occur in the same IDLE cycle, the write SHALL apply first, so the MAC pass uses the new coefficient.
REQ-026 in_valid asserted outside IDLE SHALL NOT change any state; the sample stays pending until the block returns to IDLE.

Reset
REQ-027 While reset=0 at a rising edge: state <= IDLE, x[] <= 0, acc <= 0, idx <= 0, out <= 0, out_valid <= 0, every h[k] <= 10.
REQ-028 A reset during MAC or DONE SHALL abort the pass with no out_valid pulse; in_ready is 1 in the first cycle after reset is released.

Configuration
REQ-029 Macro FIR_COEF_LOAD_EN: when defined, coefficients are register-backed and writable per REQ-024/025.
REQ-030 When FIR_COEF_LOAD_EN is undefined, every h[k] is the constant 10, coef_we/coef_addr/coef_data are ignored, and no coefficient registers are built.

Verification
REQ-031 Impulse: after reset, send 1 followed by 10 zeros -> outputs are 10 ten times, then 0.
REQ-032 Step: send 15 repeatedly -> output k (k = 1..10) = 150*k; every output after the 10th = 1500.
REQ-033 Coef load (FIR_COEF_LOAD_EN defined): write h[3]=0 and h[0]=5, then send the impulse -> outputs 5,10,10,0,10,10,10,10,10,10.
REQ-034 Back-pressure: hold in_valid=1 with a new sample each accept -> in_ready is high 1 cycle in every 12; out_valid pulses 12 cycles apart; no sample is lost or duplicated.
REQ-035 Reset mid-MAC: assert reset=0 at idx=4 -> no out_valid pulse, out=0, in_ready=1 the first cycle after release; the next impulse behaves as in REQ-031.
